// File: rtl/sid_pkg.sv
// Register map and shared constants for the SID core.
// The oscillators and sid_env import this package as well.
package sid_pkg;

    localparam int NUM_VOICES   = 3;
    localparam int VOICE_STRIDE = 7;

    // Voice-relative offsets; add VOICE_STRIDE*v for voice v
    localparam logic [4:0] REG_FREQ_LO  = 5'h00;
    localparam logic [4:0] REG_FREQ_HI  = 5'h01;
    localparam logic [4:0] REG_PW_LO    = 5'h02;
    localparam logic [4:0] REG_PW_HI    = 5'h03;
    localparam logic [4:0] REG_CTRL     = 5'h04;
    localparam logic [4:0] REG_AD       = 5'h05;
    localparam logic [4:0] REG_SR       = 5'h06;

    localparam logic [4:0] REG_FC_LO    = 5'h15;
    localparam logic [4:0] REG_FC_HI    = 5'h16;
    localparam logic [4:0] REG_RES_FILT = 5'h17;
    localparam logic [4:0] REG_MODE_VOL = 5'h18;
    localparam logic [4:0] REG_POTX     = 5'h19;
    localparam logic [4:0] REG_POTY     = 5'h1A;
    localparam logic [4:0] REG_OSC3     = 5'h1B;
    localparam logic [4:0] REG_ENV3     = 5'h1C;

    function automatic logic is_readable(input logic [4:0] addr);
        return (addr >= REG_POTX) && (addr <= REG_ENV3);
    endfunction

endpackage

// File: rtl/sid_bus_latch.sv
// SID data-bus latch: holds the last value seen on the bus and
// fades it to $00 after DECAY_CYCLES enables with no access.
module sid_bus_latch #(
    parameter int DECAY_CYCLES = 8192
) (
    input  logic       clk_i,
    input  logic       n_reset_i,
    input  logic       clk_en_i,
    input  logic       access_i,
    input  logic       load_i,
    input  logic [7:0] value_i,
    output logic [7:0] latch_o
);

    localparam int CW = $clog2(DECAY_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;
    logic [7:0]    latch_q, latch_d;

    // An access always restarts the decay window, even when it does not reload the latch
    always_comb begin
        count_d = count_q;
        latch_d = latch_q;
        if (access_i) begin
            count_d = '0;
            if (load_i) begin
                latch_d = value_i;
            end
        end else if (count_q != CW'(DECAY_CYCLES)) begin
            count_d = count_q + 1'b1;
            if (count_q == CW'(DECAY_CYCLES - 1)) begin
                latch_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            count_q <= '0;
            latch_q <= 8'h00;
        end else if (clk_en_i) begin
            count_q <= count_d;
            latch_q <= latch_d;
        end
    end

    assign latch_o = latch_q;

endmodule

// File: rtl/sid_bus_if.sv
// CPU-side register interface of the SID: decodes $00-$1F, holds the
// voice/filter/volume images and returns pots, OSC3 and ENV3 on reads.
module sid_bus_if
    import sid_pkg::*;
#(
    parameter int DECAY_CYCLES = 8192,
    parameter int VOICES       = NUM_VOICES
) (
    input  logic                    clk_i,
    input  logic                    n_reset_i,
    input  logic                    clk_en_i,
    input  logic                    cs_n_i,
    input  logic                    rw_i,
    input  logic [4:0]              addr_i,
    input  logic [7:0]              data_in_i,
    output logic [7:0]              data_out_o,
    output logic                    data_oe_o,
    input  logic [7:0]              potx_i,
    input  logic [7:0]              poty_i,
    input  logic [7:0]              osc3_i,
    input  logic [7:0]              env3_i,
    output logic [VOICES-1:0][15:0] freq_o,
    output logic [VOICES-1:0][11:0] pw_o,
    output logic [VOICES-1:0][7:0]  ctrl_o,
    output logic [VOICES-1:0][3:0]  atk_o,
    output logic [VOICES-1:0][3:0]  dcy_o,
    output logic [VOICES-1:0][3:0]  stn_o,
    output logic [VOICES-1:0][3:0]  rls_o,
    output logic [10:0]             fc_o,
    output logic [7:0]              res_filt_o,
    output logic [7:0]              mode_vol_o
);

    logic [VOICES-1:0][15:0] freq_q, freq_d;
    logic [VOICES-1:0][11:0] pw_q, pw_d;
    logic [VOICES-1:0][7:0]  ctrl_q, ctrl_d;
    logic [VOICES-1:0][7:0]  ad_q, ad_d;
    logic [VOICES-1:0][7:0]  sr_q, sr_d;
    logic [2:0]              fc_lo_q, fc_lo_d;
    logic [7:0]              fc_hi_q, fc_hi_d;
    logic [7:0]              res_filt_q, res_filt_d;
    logic [7:0]              mode_vol_q, mode_vol_d;
    logic [7:0]              data_out_q, data_out_d;
    logic                    data_oe_q, data_oe_d;

    logic       access, rd_access, wr_access, readable;
    logic [7:0] rd_value, bus_latch;

    assign access    = ~cs_n_i;
    assign rd_access = access & rw_i;
    assign wr_access = access & ~rw_i;
    assign readable  = is_readable(addr_i);

    always_comb begin
        case (addr_i)
            REG_POTX: rd_value = potx_i;
            REG_POTY: rd_value = poty_i;
            REG_OSC3: rd_value = osc3_i;
            REG_ENV3: rd_value = env3_i;
            default:  rd_value = bus_latch;
        endcase
    end

    sid_bus_latch #(
        .DECAY_CYCLES(DECAY_CYCLES)
    ) u_bus_latch (
        .clk_i     (clk_i),
        .n_reset_i (n_reset_i),
        .clk_en_i  (clk_en_i),
        .access_i  (access),
        .load_i    (wr_access | (rd_access & readable)),
        .value_i   (rw_i ? rd_value : data_in_i),
        .latch_o   (bus_latch)
    );

    // Write decode; addresses $19-$1F fall through and leave every image untouched
    always_comb begin
        freq_d     = freq_q;
        pw_d       = pw_q;
        ctrl_d     = ctrl_q;
        ad_d       = ad_q;
        sr_d       = sr_q;
        fc_lo_d    = fc_lo_q;
        fc_hi_d    = fc_hi_q;
        res_filt_d = res_filt_q;
        mode_vol_d = mode_vol_q;
        if (wr_access) begin
            for (int v = 0; v < VOICES; v++) begin
                if (addr_i == 5'(v * VOICE_STRIDE) + REG_FREQ_LO) freq_d[v][7:0]  = data_in_i;
                if (addr_i == 5'(v * VOICE_STRIDE) + REG_FREQ_HI) freq_d[v][15:8] = data_in_i;
                if (addr_i == 5'(v * VOICE_STRIDE) + REG_PW_LO)   pw_d[v][7:0]    = data_in_i;
                if (addr_i == 5'(v * VOICE_STRIDE) + REG_PW_HI)   pw_d[v][11:8]   = data_in_i[3:0];
                if (addr_i == 5'(v * VOICE_STRIDE) + REG_CTRL)    ctrl_d[v]       = data_in_i;
                if (addr_i == 5'(v * VOICE_STRIDE) + REG_AD)      ad_d[v]         = data_in_i;
                if (addr_i == 5'(v * VOICE_STRIDE) + REG_SR)      sr_d[v]         = data_in_i;
            end
            if (addr_i == REG_FC_LO)    fc_lo_d    = data_in_i[2:0];
            if (addr_i == REG_FC_HI)    fc_hi_d    = data_in_i;
            if (addr_i == REG_RES_FILT) res_filt_d = data_in_i;
            if (addr_i == REG_MODE_VOL) mode_vol_d = data_in_i;
        end
    end

    // Write-only and unused addresses read back whatever the bus latch holds
    always_comb begin
        data_oe_d  = rd_access;
        data_out_d = data_out_q;
        if (rd_access) begin
            data_out_d = readable ? rd_value : bus_latch;
        end
    end

    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            freq_q     <= '0;
            pw_q       <= '0;
            ctrl_q     <= '0;
            ad_q       <= '0;
            sr_q       <= '0;
            fc_lo_q    <= '0;
            fc_hi_q    <= '0;
            res_filt_q <= '0;
            mode_vol_q <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
        end else if (clk_en_i) begin
            freq_q     <= freq_d;
            pw_q       <= pw_d;
            ctrl_q     <= ctrl_d;
            ad_q       <= ad_d;
            sr_q       <= sr_d;
            fc_lo_q    <= fc_lo_d;
            fc_hi_q    <= fc_hi_d;
            res_filt_q <= res_filt_d;
            mode_vol_q <= mode_vol_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
        end
    end

    always_comb begin
        for (int v = 0; v < VOICES; v++) begin
            atk_o[v] = ad_q[v][7:4];
            dcy_o[v] = ad_q[v][3:0];
            stn_o[v] = sr_q[v][7:4];
            rls_o[v] = sr_q[v][3:0];
        end
    end

    assign freq_o     = freq_q;
    assign pw_o       = pw_q;
    assign ctrl_o     = ctrl_q;
    assign fc_o       = {fc_hi_q, fc_lo_q};
    assign res_filt_o = res_filt_q;
    assign mode_vol_o = mode_vol_q;
    assign data_out_o = data_out_q;
    assign data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_sid_bus_if.sv
// Directed bench for sid_bus_if: register map, read sources, bus-latch
// decay, async reset and clk_en gating, with hand-computed expectations.
module tb_sid_bus_if;
    import sid_pkg::*;

    localparam int DECAY = 8192;

    logic                clk, nReset, clkEn, csN, rw;
    logic [4:0]          addr;
    logic [7:0]          dataIn, dataOut;
    logic                dataOe;
    logic [7:0]          potx, poty, osc3, env3;
    logic [2:0][15:0]    freq;
    logic [2:0][11:0]    pw;
    logic [2:0][7:0]     ctrl;
    logic [2:0][3:0]     atk, dcy, stn, rls;
    logic [10:0]         fc;
    logic [7:0]          resFilt, modeVol;

    int compareCount  = 0;
    int mismatchCount = 0;

    sid_bus_if #(.DECAY_CYCLES(DECAY), .VOICES(3)) dut (
        .clk_i      (clk),
        .n_reset_i  (nReset),
        .clk_en_i   (clkEn),
        .cs_n_i     (csN),
        .rw_i       (rw),
        .addr_i     (addr),
        .data_in_i  (dataIn),
        .data_out_o (dataOut),
        .data_oe_o  (dataOe),
        .potx_i     (potx),
        .poty_i     (poty),
        .osc3_i     (osc3),
        .env3_i     (env3),
        .freq_o     (freq),
        .pw_o       (pw),
        .ctrl_o     (ctrl),
        .atk_o      (atk),
        .dcy_o      (dcy),
        .stn_o      (stn),
        .rls_o      (rls),
        .fc_o       (fc),
        .res_filt_o (resFilt),
        .mode_vol_o (modeVol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", tag, actual, expected);
        end
    endtask

    // One enabled bus access; outputs are sampled 1ns after the capturing edge
    task automatic applyStimulus(input logic isRead, input logic [4:0] a, input logic [7:0] d);
        csN    = 1'b0;
        rw     = isRead;
        addr   = a;
        dataIn = d;
        @(posedge clk);
        #1;
        csN = 1'b1;
        rw  = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        csN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        nReset = 1'b0;
        clkEn  = 1'b1;
        csN    = 1'b1;
        rw     = 1'b1;
        addr   = '0;
        dataIn = '0;
        potx   = 8'h12;
        poty   = 8'h34;
        osc3   = 8'h56;
        env3   = 8'h78;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset data_out", dataOut, 8'h00);
        checkOutput("reset data_oe", dataOe, 1'b0);
        checkOutput("reset freq0", freq[0], 16'h0000);
        checkOutput("reset mode_vol", modeVol, 8'h00);
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: write-only/unused addresses first so the latch is still $00
        for (int a = 0; a < 32; a++) begin
            if (a < 'h19 || a > 'h1C) begin
                applyStimulus(1'b1, 5'(a), 8'h00);
                checkOutput($sformatf("t1 read %02h", a), dataOut, 8'h00);
                checkOutput($sformatf("t1 oe %02h", a), dataOe, 1'b1);
            end
        end
        applyStimulus(1'b1, 5'h19, 8'h00); checkOutput("t1 potx", dataOut, 8'h12);
        applyStimulus(1'b1, 5'h1A, 8'h00); checkOutput("t1 poty", dataOut, 8'h34);
        applyStimulus(1'b1, 5'h1B, 8'h00); checkOutput("t1 osc3", dataOut, 8'h56);
        applyStimulus(1'b1, 5'h1C, 8'h00); checkOutput("t1 env3", dataOut, 8'h78);
        idleCycles(1);
        checkOutput("t1 oe drops", dataOe, 1'b0);
        checkOutput("t1 data_out holds", dataOut, 8'h78);

        // Test 2: voice 3 registers
        applyStimulus(1'b0, 5'h0E, 8'hAB); checkOutput("t2 freq lo", freq[2], 16'h00AB);
        applyStimulus(1'b0, 5'h0F, 8'hCD); checkOutput("t2 freq", freq[2], 16'hCDAB);
        applyStimulus(1'b0, 5'h12, 8'h41); checkOutput("t2 ctrl", ctrl[2], 8'h41);
        checkOutput("t2 gate", ctrl[2][0], 1'b1);
        checkOutput("t2 write oe", dataOe, 1'b0);
        applyStimulus(1'b0, 5'h13, 8'hA9);
        checkOutput("t2 atk", atk[2], 4'hA);
        checkOutput("t2 dcy", dcy[2], 4'h9);
        applyStimulus(1'b0, 5'h14, 8'hF3);
        checkOutput("t2 stn", stn[2], 4'hF);
        checkOutput("t2 rls", rls[2], 4'h3);
        checkOutput("t2 voice0 ctrl", ctrl[0], 8'h00);

        // Test 3: dropped bits and writes to read-only space
        applyStimulus(1'b0, 5'h03, 8'hFF); checkOutput("t3 pw0", pw[0], 12'hF00);
        applyStimulus(1'b0, 5'h15, 8'hFF); checkOutput("t3 fc", fc, 11'h007);
        applyStimulus(1'b0, 5'h19, 8'h99);
        checkOutput("t3 pw0 kept", pw[0], 12'hF00);
        checkOutput("t3 fc kept", fc, 11'h007);
        checkOutput("t3 freq2 kept", freq[2], 16'hCDAB);
        checkOutput("t3 ctrl2 kept", ctrl[2], 8'h41);
        checkOutput("t3 res_filt kept", resFilt, 8'h00);
        checkOutput("t3 mode_vol kept", modeVol, 8'h00);
        applyStimulus(1'b1, 5'h00, 8'h00); checkOutput("t3 latch 99", dataOut, 8'h99);

        // Test 4: latch readback and decay boundary
        applyStimulus(1'b0, 5'h18, 8'h5A); checkOutput("t4 mode_vol", modeVol, 8'h5A);
        applyStimulus(1'b1, 5'h00, 8'h00);
        checkOutput("t4 read 00", dataOut, 8'h5A);
        checkOutput("t4 oe", dataOe, 1'b1);
        idleCycles(DECAY - 1);
        applyStimulus(1'b1, 5'h05, 8'h00); checkOutput("t4 before decay", dataOut, 8'h5A);
        idleCycles(DECAY);
        applyStimulus(1'b1, 5'h05, 8'h00); checkOutput("t4 after decay", dataOut, 8'h00);

        // Test 5: readable sources reload the latch
        env3 = 8'h80;
        applyStimulus(1'b1, 5'h1C, 8'h00); checkOutput("t5 env3", dataOut, 8'h80);
        applyStimulus(1'b1, 5'h00, 8'h00); checkOutput("t5 latch env3", dataOut, 8'h80);
        osc3 = 8'hC3;
        applyStimulus(1'b1, 5'h1B, 8'h00); checkOutput("t5 osc3", dataOut, 8'hC3);
        applyStimulus(1'b1, 5'h00, 8'h00); checkOutput("t5 latch osc3", dataOut, 8'hC3);

        // Test 6: held chip select, async reset mid-stream, clk_en gating
        csN = 1'b0; rw = 1'b0; addr = 5'h04; dataIn = 8'h11;
        @(posedge clk); #1;
        checkOutput("t6 ctrl0 written", ctrl[0], 8'h11);
        rw = 1'b1; addr = 5'h00;
        @(posedge clk); #1;
        checkOutput("t6 held read", dataOut, 8'h11);
        checkOutput("t6 held oe", dataOe, 1'b1);
        rw = 1'b0; addr = 5'h04; dataIn = 8'h11;
        #2;
        nReset = 1'b0;
        #1;
        checkOutput("t6 rst ctrl0", ctrl[0], 8'h00);
        checkOutput("t6 rst oe", dataOe, 1'b0);
        checkOutput("t6 rst data_out", dataOut, 8'h00);
        csN = 1'b1;
        @(negedge clk);
        nReset = 1'b1;
        applyStimulus(1'b1, 5'h00, 8'h00);
        checkOutput("t6 rst latch", dataOut, 8'h00);
        clkEn = 1'b0;
        csN = 1'b0; rw = 1'b0; addr = 5'h04; dataIn = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6 gated write", ctrl[0], 8'h00);
        rw = 1'b1; addr = 5'h19;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6 gated read oe", dataOe, 1'b1);
        checkOutput("t6 gated read data", dataOut, 8'h00);
        csN = 1'b1;
        clkEn = 1'b1;
        applyStimulus(1'b1, 5'h00, 8'h00);
        checkOutput("t6 gated latch", dataOut, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
